mem_arbiter: RTL and testbench

//  Shares the single DPI-backed data memory port between IFU (read-only fetch) and LSU (load/store).

---
 rtl/npc_mem_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the NPC memory-port arbiter.
// Arbitration policy is selected in mem_arbiter via MEM_ARB_RR_EN.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant selection: fixed LSU priority, or round-robin
// against last_owner_i when RR_EN is set.
module mem_arb_pick
  import npc_mem_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic   ifu_valid_i,
  input  logic   lsu_valid_i,
  input  owner_t last_owner_i,
  output logic   grant_ifu_o,
  output logic   grant_lsu_o
);

  always_comb begin
    grant_ifu_o = 1'b0;
    grant_lsu_o = 1'b0;
    if (ifu_valid_i && lsu_valid_i) begin
      // On contention, round-robin hands the port to whoever did not win last.
      if (RR_EN && (last_owner_i == OWN_LSU)) grant_ifu_o = 1'b1;
      else                                    grant_lsu_o = 1'b1;
    end else begin
      grant_ifu_o = ifu_valid_i;
      grant_lsu_o = lsu_valid_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  output logic              ifu_rsp_valid,
  output logic [WIDTH-1:0]  ifu_rsp_data,
  input  logic              ifu_rsp_ready,
  input  logic              lsu_req_valid,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [1:0]        lsu_req_len,
  input  logic [WIDTH-1:0]  lsu_req_wdata,
  output logic              lsu_req_ready,
  output logic              lsu_rsp_valid,
  output logic [WIDTH-1:0]  lsu_rsp_data,
  input  logic              lsu_rsp_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [1:0]        mem_req_len,
  output logic [WIDTH-1:0]  mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [WIDTH-1:0]  mem_rsp_data,
  output logic              mem_rsp_ready
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [1:0]        len_q, len_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  owner_t last_owner;
  logic   grant_ifu, grant_lsu;
  logic   ifu_hs, lsu_hs;
  logic   owner_rsp_ready;

`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
  owner_t last_owner_q, last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (ifu_hs)      last_owner_d = OWN_IFU;
    else if (lsu_hs) last_owner_d = OWN_LSU;
  end

  always_ff @(posedge clk) begin
    if (rst) last_owner_q <= OWN_LSU;
    else     last_owner_q <= last_owner_d;
  end

  assign last_owner = last_owner_q;
`else
  localparam bit RrEn = 1'b0;
  assign last_owner = OWN_LSU;
`endif

  mem_arb_pick #(
    .RR_EN(RrEn)
  ) u_pick (
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
    .last_owner_i(last_owner),
    .grant_ifu_o (grant_ifu),
    .grant_lsu_o (grant_lsu)
  );

  assign ifu_req_ready = (state_q == S_IDLE) && grant_ifu;
  assign lsu_req_ready = (state_q == S_IDLE) && grant_lsu;
  assign ifu_hs        = ifu_req_valid && ifu_req_ready;
  assign lsu_hs        = lsu_req_valid && lsu_req_ready;

  assign owner_rsp_ready = (owner_q == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_hs) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          len_d   = LEN_W;
          wdata_d = '0;
          state_d = S_REQ;
        end else if (lsu_hs) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          len_d   = lsu_req_len;
          wdata_d = lsu_req_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_RSP;
      end
      S_RSP: begin
        if (mem_rsp_valid) begin
          // Stores return a zero acknowledge regardless of what memory drives.
          rsp_data_d = wen_q ? '0 : mem_rsp_data;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (owner_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      len_q      <= 2'b00;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_len   = len_q;
  assign mem_req_wdata = wdata_q;
  assign mem_rsp_ready = (state_q == S_RSP);

  assign ifu_rsp_valid = (state_q == S_DONE) && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = (state_q == S_DONE) && (owner_q == OWN_LSU);
  assign ifu_rsp_data  = rsp_data_q;
  assign lsu_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the round-robin scenario is
// compiled in when MEM_ARB_RR_EN is defined, the fixed-priority one otherwise.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [1:0]  lsu_req_len;
  logic        mem_req_valid, mem_req_wen, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [1:0]  mem_req_len;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WIDTH (32),
    .ADDR_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_addr (ifu_req_addr),
    .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data (ifu_rsp_data),
    .ifu_rsp_ready(ifu_rsp_ready),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_addr (lsu_req_addr),
    .lsu_req_wen  (lsu_req_wen),
    .lsu_req_len  (lsu_req_len),
    .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_data (lsu_rsp_data),
    .lsu_rsp_ready(lsu_rsp_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_wen  (mem_req_wen),
    .mem_req_len  (mem_req_len),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_ready(mem_rsp_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_valid got %b want 0", mem_req_valid); end
    n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rsp_ready got %b want 0", mem_rsp_ready); end
    n_cmp++; if (ifu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ifu_rsp_valid got %b want 0", ifu_rsp_valid); end
    n_cmp++; if (lsu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_rsp_valid got %b want 0", lsu_rsp_valid); end
    n_cmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready got %b want 00", {ifu_req_ready, lsu_req_ready}); end
    n_cmp++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_req_addr got %h want 0", mem_req_addr); end
    n_cmp++; if (ifu_rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_data got %h want 0", ifu_rsp_data); end
  endtask

  task automatic test_ifu_fetch();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    n_cmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL f_req_ready got %b want 10", {ifu_req_ready, lsu_req_ready}); end
    tick();
    ifu_req_valid = 1'b0;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL f_mem_req_valid got %b want 1", mem_req_valid); end
    n_cmp++; if ({mem_req_addr, mem_req_wen, mem_req_len} !== {32'h8000_0000, 1'b0, 2'b10}) begin n_fail++; $display("FAIL f_mem_fields got %h/%b/%b want 80000000/0/10", mem_req_addr, mem_req_wen, mem_req_len); end
    n_cmp++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL f_ready_busy got %b want 0", ifu_req_ready); end
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0413;
    #1;
    n_cmp++; if ({mem_rsp_ready, ifu_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL f_rsp_phase got %b want 10", {mem_rsp_ready, ifu_rsp_valid}); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL f_rsp_valid got %b want 10", {ifu_rsp_valid, lsu_rsp_valid}); end
    n_cmp++; if (ifu_rsp_data !== 32'h0000_0413) begin n_fail++; $display("FAIL f_rsp_data got %h want 00000413", ifu_rsp_data); end
    tick();
    #1;
    n_cmp++; if (ifu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL f_rsp_drop got %b want 0", ifu_rsp_valid); end
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_round_robin();
    logic exp_ifu;
    do_reset();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0010;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h8000_0400;
    lsu_req_wen   = 1'b0;
    lsu_req_len   = 2'b10;
    exp_ifu       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, ~exp_ifu}) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", i, {ifu_req_ready, lsu_req_ready}, {exp_ifu, ~exp_ifu}); end
      tick();
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h100 + i;
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      n_cmp++; if ({ifu_rsp_valid, lsu_rsp_valid} !== {exp_ifu, ~exp_ifu}) begin n_fail++; $display("FAIL rr_rsp%0d got %b want %b", i, {ifu_rsp_valid, lsu_rsp_valid}, {exp_ifu, ~exp_ifu}); end
      tick();
      exp_ifu = ~exp_ifu;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask
`else
  task automatic test_priority();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h8000_0200;
    lsu_req_wen   = 1'b0;
    lsu_req_len   = 2'b01;
    #1;
    n_cmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin n_fail++; $display("FAIL p_grant got %b want 01", {ifu_req_ready, lsu_req_ready}); end
    tick();
    lsu_req_valid = 1'b0;
    #1;
    n_cmp++; if ({mem_req_addr, mem_req_len} !== {32'h8000_0200, 2'b01}) begin n_fail++; $display("FAIL p_mem_fields got %h/%b want 80000200/01", mem_req_addr, mem_req_len); end
    n_cmp++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL p_ifu_wait got %b want 0", ifu_req_ready); end
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_1234;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL p_rsp_valid got %b want 01", {ifu_rsp_valid, lsu_rsp_valid}); end
    n_cmp++; if (lsu_rsp_data !== 32'h0000_1234) begin n_fail++; $display("FAIL p_rsp_data got %h want 00001234", lsu_rsp_data); end
    n_cmp++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL p_done_ready got %b want 0", ifu_req_ready); end
    tick();
    #1;
    n_cmp++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL p_b2b_ready got %b want 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0;
    #1;
    n_cmp++; if (mem_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL p_ifu_addr got %h want 80000004", mem_req_addr); end
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0013;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({ifu_rsp_valid, ifu_rsp_data} !== {1'b1, 32'h0000_0013}) begin n_fail++; $display("FAIL p_ifu_rsp got %b/%h want 1/00000013", ifu_rsp_valid, ifu_rsp_data); end
    tick();
  endtask
`endif

  task automatic test_store();
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b1;
    lsu_req_addr  = 32'h8000_0100;
    lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_len   = 2'b10;
    #1;
    n_cmp++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL s_ready got %b want 1", lsu_req_ready); end
    tick();
    lsu_req_valid = 1'b0;
    #1;
    n_cmp++; if ({mem_req_valid, mem_req_wen, mem_req_len} !== 4'b1110) begin n_fail++; $display("FAIL s_ctl got %b want 1110", {mem_req_valid, mem_req_wen, mem_req_len}); end
    n_cmp++; if ({mem_req_addr, mem_req_wdata} !== {32'h8000_0100, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL s_addr_data got %h/%h want 80000100/deadbeef", mem_req_addr, mem_req_wdata); end
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({lsu_rsp_valid, lsu_rsp_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL s_rsp got %b/%h want 1/00000000", lsu_rsp_valid, lsu_rsp_data); end
    tick();
    lsu_req_wen = 1'b0;
  endtask

  task automatic test_stall();
    mem_req_ready = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h8000_0300;
    lsu_req_len   = 2'b00;
    tick();
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0008;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({mem_req_valid, mem_req_addr, mem_req_len} !== {1'b1, 32'h8000_0300, 2'b00}) begin n_fail++; $display("FAIL st_req%0d got %b/%h/%b want 1/80000300/00", i, mem_req_valid, mem_req_addr, mem_req_len); end
      n_cmp++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL st_req_grant%0d got %b want 0", i, ifu_req_ready); end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    lsu_rsp_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_00A5;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({lsu_rsp_valid, lsu_rsp_data} !== {1'b1, 32'h0000_00A5}) begin n_fail++; $display("FAIL st_rsp%0d got %b/%h want 1/000000a5", i, lsu_rsp_valid, lsu_rsp_data); end
      n_cmp++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL st_rsp_grant%0d got %b want 0", i, ifu_req_ready); end
      tick();
    end
    lsu_rsp_ready = 1'b1;
    tick();
    #1;
    n_cmp++; if ({ifu_req_ready, lsu_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL st_release got %b want 10", {ifu_req_ready, lsu_rsp_valid}); end
    tick();
    ifu_req_valid = 1'b0;
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0093;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({ifu_rsp_valid, ifu_rsp_data} !== {1'b1, 32'h0000_0093}) begin n_fail++; $display("FAIL st_ifu_rsp got %b/%h want 1/00000093", ifu_rsp_valid, ifu_rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_000C;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_rsp got %b want 1", mem_rsp_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 4'b0000) begin n_fail++; $display("FAIL rm_valids got %b want 0000", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}); end
    n_cmp++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr got %h want 0", mem_req_addr); end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1111_2222;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin n_fail++; $display("FAIL rm_late_rsp got %b want 000", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}); end
    n_cmp++; if (ifu_rsp_data !== 32'h0) begin n_fail++; $display("FAIL rm_data got %h want 0", ifu_rsp_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wen   = 1'b0;
    lsu_req_len   = 2'b00;
    lsu_req_wdata = '0;
    lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    test_reset();
    test_ifu_fetch();
`ifdef MEM_ARB_RR_EN
    test_round_robin();
`else
    test_priority();
`endif
    test_store();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
